adc3664_spi_master: RTL and testbench

SPI master (initiator) for the ADC3664 serial configuration port. Accepts register-access requests on a simple start/busy/done handshake, serialises each as a 24-bit frame on SEN/SCLK/SDIO, and for reads captures returned data from SDOUT. It drives the same frame format the ADC-side slave decodes: R/W, 3 reserved bits, a 12-bit address, then 8 data bits, all MSB first.

---
 rtl/adc3664_spi_pkg.sv | 39 +++
 rtl/adc3664_spi_master_if.sv | 23 ++
 rtl/adc3664_spi_tick.sv | 30 +++
 rtl/adc3664_spi_master.sv | 153 +++++++++++++++
 tb/tb_adc3664_spi_master.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc3664_spi_pkg.sv
// Shared frame layout and FSM encoding for the ADC3664 serial configuration port.
// Used by both the SPI master and the ADC-side slave decoder.
package adc3664_spi_pkg;

    localparam int unsigned FRAME_BITS = 24;
    localparam int unsigned ADDR_BITS  = 12;
    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned BIT_CNT_W  = 5;

    localparam int unsigned RW_BIT   = 23;
    localparam int unsigned ADDR_MSB = 19;
    localparam int unsigned ADDR_LSB = 8;

    localparam logic [BIT_CNT_W-1:0] LAST_BIT    = BIT_CNT_W'(FRAME_BITS - 1);
    localparam logic [BIT_CNT_W-1:0] FIRST_RD_BIT = BIT_CNT_W'(FRAME_BITS - DATA_BITS);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } spi_state_e;

    // Reads carry an all-zero data field; the slave drives SDOUT during it.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic                 rw,
        input logic [ADDR_BITS-1:0] addr,
        input logic [DATA_BITS-1:0] data
    );
        logic [FRAME_BITS-1:0] f;
        f                    = '0;
        f[RW_BIT]            = rw;
        f[ADDR_MSB:ADDR_LSB] = addr;
        f[DATA_BITS-1:0]     = rw ? '0 : data;
        return f;
    endfunction

endpackage

// File: rtl/adc3664_spi_master_if.sv
// Register-access request bus between a configuration host and the SPI master.
interface adc3664_spi_master_if;
    import adc3664_spi_pkg::*;

    logic                 start;
    logic                 rw;
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] wdata;
    logic                 busy;
    logic                 done;
    logic [DATA_BITS-1:0] rdata;

    modport master (
        output start, rw, addr, wdata,
        input  busy, done, rdata
    );

    modport slave (
        input  start, rw, addr, wdata,
        output busy, done, rdata
    );

endinterface

// File: rtl/adc3664_spi_tick.sv
// Half-period tick generator: pulses tick every CLK_DIV enabled cycles.
// clr restarts the count so the first tick lands CLK_DIV cycles after frame start.
module adc3664_spi_tick #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic CLK,
    input  logic Reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;

    assign tick = en && (cnt_q == LAST);

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tick ? '0 : cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/adc3664_spi_master.sv
// SPI master for the ADC3664 configuration port: 24-bit R/W frames on SEN/SCLK/SDIO,
// read data captured from SDOUT during the data field.
module adc3664_spi_master
    import adc3664_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic                 CLK,
    input  logic                 Reset,
    adc3664_spi_master_if.slave  bus,
    output logic                 SCLK,
    output logic                 SEN,
    output logic                 SDIO,
    input  logic                 SDOUT
);

    spi_state_e state_q, state_d;

    logic                  sclk_q, sclk_d;
    logic                  sen_q, sen_d;
    logic                  sdio_q, sdio_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  rw_q, rw_d;
    logic [DATA_BITS-1:0]  rdata_q, rdata_d;
    logic [DATA_BITS-1:0]  cap_q, cap_d;
    logic [FRAME_BITS-1:0] sreg_q, sreg_d;
    logic [BIT_CNT_W-1:0]  bit_q, bit_d;
    logic [FRAME_BITS-1:0] frame;
    logic                  tick;
    logic                  tick_clr;

    adc3664_spi_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .CLK   (CLK),
        .Reset (Reset),
        .en    (state_q != IDLE),
        .clr   (tick_clr),
        .tick  (tick)
    );

    assign frame = build_frame(bus.rw, bus.addr, bus.wdata);

    always_comb begin
        state_d  = state_q;
        sclk_d   = sclk_q;
        sen_d    = sen_q;
        sdio_d   = sdio_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        rw_d     = rw_q;
        rdata_d  = rdata_q;
        cap_d    = cap_q;
        sreg_d   = sreg_q;
        bit_d    = bit_q;
        tick_clr = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sreg_d   = frame;
                    rw_d     = bus.rw;
                    sen_d    = 1'b0;
                    sdio_d   = frame[RW_BIT];
                    busy_d   = 1'b1;
                    bit_d    = '0;
                    tick_clr = 1'b1;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                if (tick) begin
                    sclk_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (sclk_q) begin
                        // Falling edge: advance SDIO and capture SDOUT for the data field.
                        sclk_d = 1'b0;
                        sdio_d = (bit_q == LAST_BIT) ? 1'b0 : sreg_q[FRAME_BITS-2];
                        sreg_d = {sreg_q[FRAME_BITS-2:0], 1'b0};
                        if (bit_q >= FIRST_RD_BIT) begin
                            cap_d = {cap_q[DATA_BITS-2:0], SDOUT};
                        end
                    end else if (bit_q == LAST_BIT) begin
                        state_d = HOLD;
                    end else begin
                        bit_d  = bit_q + BIT_CNT_W'(1);
                        sclk_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    sen_d  = 1'b1;
                    done_d = 1'b1;
                    if (rw_q) begin
                        rdata_d = cap_q;
                    end
                    state_d = GAP;
                end
            end
            GAP: begin
                if (tick) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            sclk_q  <= 1'b0;
            sen_q   <= 1'b1;
            sdio_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rw_q    <= 1'b0;
            rdata_q <= '0;
            cap_q   <= '0;
            sreg_q  <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            sclk_q  <= sclk_d;
            sen_q   <= sen_d;
            sdio_q  <= sdio_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rw_q    <= rw_d;
            rdata_q <= rdata_d;
            cap_q   <= cap_d;
            sreg_q  <= sreg_d;
            bit_q   <= bit_d;
        end
    end

    assign SCLK      = sclk_q;
    assign SEN       = sen_q;
    assign SDIO      = sdio_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_adc3664_spi_master.sv
// Bench for adc3664_spi_master: two instances (CLK_DIV=2 and CLK_DIV=1) checked
// against a frame-level model of SEN/SCLK/SDIO timing and read data.
module tb_adc3664_spi_master;

    logic CLK   = 1'b0;
    logic Reset = 1'b1;
    always #5 CLK = ~CLK;

    adc3664_spi_master_if bus0 ();
    adc3664_spi_master_if bus1 ();

    logic [1:0]  start_v, rw_v, busy_v, done_v, sclk_v, sen_v, sdio_v, sdout_v;
    logic [11:0] addr_v  [2];
    logic [7:0]  wdata_v [2];
    logic [7:0]  rdata_v [2];
    logic [7:0]  rd_val  [2];

    assign bus0.start = start_v[0];
    assign bus0.rw    = rw_v[0];
    assign bus0.addr  = addr_v[0];
    assign bus0.wdata = wdata_v[0];
    assign bus1.start = start_v[1];
    assign bus1.rw    = rw_v[1];
    assign bus1.addr  = addr_v[1];
    assign bus1.wdata = wdata_v[1];
    assign busy_v[0]  = bus0.busy;
    assign busy_v[1]  = bus1.busy;
    assign done_v[0]  = bus0.done;
    assign done_v[1]  = bus1.done;
    assign rdata_v[0] = bus0.rdata;
    assign rdata_v[1] = bus1.rdata;

    adc3664_spi_master #(.CLK_DIV(2)) u_dut_h2 (
        .CLK(CLK), .Reset(Reset), .bus(bus0),
        .SCLK(sclk_v[0]), .SEN(sen_v[0]), .SDIO(sdio_v[0]), .SDOUT(sdout_v[0])
    );

    adc3664_spi_master #(.CLK_DIV(1)) u_dut_h1 (
        .CLK(CLK), .Reset(Reset), .bus(bus1),
        .SCLK(sclk_v[1]), .SEN(sen_v[1]), .SDIO(sdio_v[1]), .SDOUT(sdout_v[1])
    );

    int unsigned tests_run = 0;
    int unsigned tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Monitor: observes pins at negedge, logs per-frame results and acts as SDOUT slave.
    int unsigned cyc = 0;
    logic [1:0]  sclk_p, sen_p, busy_p, in_frame;
    int unsigned rises[2], fall_cyc[2], rise_cyc[2], first_rise[2], second_rise[2];
    int unsigned frames[2], dones[2], busy_fall[2], done_cyc[2];
    int unsigned last_rises[2], last_low[2], last_gap[2], last_first[2], last_period[2];
    logic [23:0] acc[2], last_frame[2], prev_frame[2];
    logic [7:0]  done_rdata[2];

    always @(negedge CLK) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (Reset) begin
                rises[d]    = 0;
                in_frame[d] = 1'b0;
                sdout_v[d]  = 1'b0;
            end else begin
                if (sen_p[d] === 1'b1 && sen_v[d] === 1'b0) begin
                    last_gap[d] = cyc - rise_cyc[d];
                    fall_cyc[d] = cyc;
                    rises[d]    = 0;
                    acc[d]      = '0;
                    in_frame[d] = 1'b1;
                end
                if (in_frame[d] && sclk_p[d] === 1'b0 && sclk_v[d] === 1'b1) begin
                    acc[d] = {acc[d][22:0], sdio_v[d]};
                    rises[d]++;
                    if (rises[d] == 1) first_rise[d] = cyc;
                    if (rises[d] == 2) second_rise[d] = cyc;
                    if (rises[d] >= 17 && rises[d] <= 24) begin
                        int idx;
                        idx = 24 - int'(rises[d]);
                        sdout_v[d] = rd_val[d][idx[2:0]];
                    end else begin
                        sdout_v[d] = 1'b0;
                    end
                end
                if (done_v[d] === 1'b1) begin
                    dones[d]++;
                    done_cyc[d]   = cyc;
                    done_rdata[d] = rdata_v[d];
                end
                if (in_frame[d] && sen_p[d] === 1'b0 && sen_v[d] === 1'b1) begin
                    rise_cyc[d]    = cyc;
                    frames[d]++;
                    prev_frame[d]  = last_frame[d];
                    last_frame[d]  = acc[d];
                    last_rises[d]  = rises[d];
                    last_low[d]    = cyc - fall_cyc[d];
                    last_first[d]  = first_rise[d] - fall_cyc[d];
                    last_period[d] = second_rise[d] - first_rise[d];
                    in_frame[d]    = 1'b0;
                end
                if (busy_p[d] === 1'b1 && busy_v[d] === 1'b0) busy_fall[d] = cyc;
            end
            sclk_p[d] = sclk_v[d];
            sen_p[d]  = sen_v[d];
            busy_p[d] = busy_v[d];
        end
    end

    logic [7:0] exp_rdata [2];

    function automatic logic [23:0] model_frame(input logic rw, input logic [11:0] a, input logic [7:0] w);
        int unsigned v;
        v = (int'(rw) * (1 << 23)) + (int'(a) * 256) + (rw ? 0 : int'(w));
        return v[23:0];
    endfunction

    task automatic wait_idle(input int d);
        int unsigned n;
        n = 0;
        while (busy_v[d] !== 1'b0 && n < 300) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 300) check("busy_timeout", 32'(busy_v[d]), 32'd0);
    endtask

    task automatic do_frame(input int d, input logic rw, input logic [11:0] a,
                            input logic [7:0] w, input logic [7:0] rv, input bit poke);
        int unsigned f0, d0, n, h;
        logic [23:0] exp;
        h   = (d == 0) ? 2 : 1;
        exp = model_frame(rw, a, w);
        wait_idle(d);
        f0 = frames[d];
        d0 = dones[d];
        rd_val[d]  = rv;
        rw_v[d]    = rw;
        addr_v[d]  = a;
        wdata_v[d] = w;
        start_v[d] = 1'b1;
        @(negedge CLK);
        start_v[d] = 1'b0;
        if (poke) begin
            repeat (9) @(negedge CLK);
            rw_v[d]    = ~rw;
            addr_v[d]  = ~a;
            start_v[d] = 1'b1;
            @(negedge CLK);
            start_v[d] = 1'b0;
        end
        n = 0;
        while (frames[d] == f0 && n < 400) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 400) check("frame_timeout", 32'(frames[d] - f0), 32'd1);
        wait_idle(d);
        repeat (2 * h + 4) @(negedge CLK);
        if (rw) exp_rdata[d] = rv;
        check("frame",        32'(last_frame[d]), 32'(exp));
        check("rises",        last_rises[d], 32'd24);
        check("sen_low",      last_low[d], 50 * h);
        check("first_rise",   last_first[d], h);
        check("sclk_period",  last_period[d], 2 * h);
        check("frame_count",  frames[d] - f0, 32'd1);
        check("done_count",   dones[d] - d0, 32'd1);
        check("done_at_sen",  done_cyc[d], rise_cyc[d]);
        check("rdata_done",   32'(done_rdata[d]), 32'(exp_rdata[d]));
        check("busy_fall",    busy_fall[d] - rise_cyc[d], h);
        check("rdata_hold",   32'(rdata_v[d]), 32'(exp_rdata[d]));
        check("sen_idle",     32'(sen_v[d]), 32'd1);
    endtask

    initial begin
        int unsigned f0, d0, n;
        start_v = '0;
        rw_v    = '0;
        for (int d = 0; d < 2; d++) begin
            addr_v[d]    = '0;
            wdata_v[d]   = '0;
            rd_val[d]    = '0;
            exp_rdata[d] = '0;
        end
        repeat (3) @(negedge CLK);
        Reset = 1'b0;
        @(negedge CLK);
        for (int d = 0; d < 2; d++) begin
            check("rst_sen",   32'(sen_v[d]),   32'd1);
            check("rst_sclk",  32'(sclk_v[d]),  32'd0);
            check("rst_sdio",  32'(sdio_v[d]),  32'd0);
            check("rst_busy",  32'(busy_v[d]),  32'd0);
            check("rst_done",  32'(done_v[d]),  32'd0);
            check("rst_rdata", 32'(rdata_v[d]), 32'd0);
        end

        do_frame(0, 1'b0, 12'h0A5, 8'h3C, 8'hC3, 1'b0);
        do_frame(0, 1'b1, 12'h123, 8'h77, 8'h5A, 1'b0);
        do_frame(0, 1'b0, 12'h456, 8'h9E, 8'hFF, 1'b1);

        // start held high: two frames back to back with minimum SEN high time
        wait_idle(0);
        f0 = frames[0];
        d0 = dones[0];
        rd_val[0]  = 8'hA6;
        rw_v[0]    = 1'b0;
        addr_v[0]  = 12'h321;
        wdata_v[0] = 8'h18;
        start_v[0] = 1'b1;
        n = 0;
        while (sen_v[0] !== 1'b0 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        rw_v[0]   = 1'b1;
        addr_v[0] = 12'hABC;
        n = 0;
        while (frames[0] < f0 + 2 && n < 600) begin
            @(negedge CLK);
            n++;
        end
        start_v[0] = 1'b0;
        if (n >= 600) check("held_timeout", frames[0] - f0, 32'd2);
        wait_idle(0);
        repeat (8) @(negedge CLK);
        exp_rdata[0] = 8'hA6;
        check("held_frame_a", 32'(prev_frame[0]), 32'(model_frame(1'b0, 12'h321, 8'h18)));
        check("held_frame_b", 32'(last_frame[0]), 32'(model_frame(1'b1, 12'hABC, 8'h00)));
        check("held_gap",     last_gap[0], 32'd3);
        check("held_frames",  frames[0] - f0, 32'd2);
        check("held_dones",   dones[0] - d0, 32'd2);
        check("held_rdata",   32'(rdata_v[0]), 32'(exp_rdata[0]));

        // reset in the middle of a read frame
        wait_idle(0);
        f0 = frames[0];
        d0 = dones[0];
        rd_val[0]  = 8'h33;
        rw_v[0]    = 1'b1;
        addr_v[0]  = 12'h777;
        start_v[0] = 1'b1;
        @(negedge CLK);
        start_v[0] = 1'b0;
        n = 0;
        while (rises[0] < 10 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 200) check("rst_wait_timeout", rises[0], 32'd10);
        Reset = 1'b1;
        #1;
        check("midrst_sen",  32'(sen_v[0]),  32'd1);
        check("midrst_sclk", 32'(sclk_v[0]), 32'd0);
        check("midrst_sdio", 32'(sdio_v[0]), 32'd0);
        check("midrst_busy", 32'(busy_v[0]), 32'd0);
        check("midrst_done", 32'(done_v[0]), 32'd0);
        repeat (2) @(negedge CLK);
        Reset = 1'b0;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        repeat (10) @(negedge CLK);
        check("midrst_frames", frames[0] - f0, 32'd0);
        check("midrst_dones",  dones[0] - d0, 32'd0);
        check("midrst_rdata",  32'(rdata_v[0]), 32'd0);
        do_frame(0, 1'b1, 12'h5C3, 8'h00, 8'h96, 1'b0);

        do_frame(1, 1'b0, 12'hFFF, 8'hFF, 8'h00, 1'b0);
        do_frame(1, 1'b1, 12'h001, 8'h00, 8'h81, 1'b1);

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++) begin
                logic [31:0] r;
                r = $urandom;
                do_frame(d, r[31], r[11:0], r[19:12], r[27:20], r[30]);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got %0d checks, required completion", tests_run);
        $fatal(1, "timeout");
    end

endmodule
